mem_port_arbiter: RTL and testbench

- Shares the single data-memory port (the pmem read/write path behind the load/store stage) between two requesters: instruction fetch (IFU, read-only) and load/store (LSU, read or write).
- Allows one outstanding transaction. Requests use a valid/ready handshake; responses use a single-cycle resp_valid pulse.
- LSU has fixed priority. A starvation counter forces an IFU grant when IFU has waited too long.
- Sits between the IFU/LSU stages and the memory adapter that drives dpic_pmem_read/dpic_pmem_write.

---
 rtl/mem_port_arbiter.sv | 161 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the single data-memory port: LSU has fixed priority,
// IFU is forced after STARVE_LIMIT back-to-back LSU grants, one transaction in flight.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MASK_W       = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              ifu_req_valid,
  output logic              ifu_req_ready,
  input  logic [ADDR_W-1:0] ifu_addr,
  output logic              ifu_resp_valid,
  output logic [DATA_W-1:0] ifu_rdata,

  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic              lsu_wen,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic [DATA_W-1:0] lsu_wdata,
  input  logic [MASK_W-1:0] lsu_wmask,
  output logic              lsu_resp_valid,
  output logic [DATA_W-1:0] lsu_rdata,

  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [MASK_W-1:0] mem_wmask,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_rdata,

  output logic              owner,
  output logic              busy
);

  localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                owner_q, owner_d;
  logic [CNT_W-1:0]    starve_cnt_q, starve_cnt_d;
  logic                wen_q, wen_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [MASK_W-1:0]   wmask_q, wmask_d;

  logic                idle;
  logic                any_valid;
  logic                ifu_wins;
  logic                ifu_hs;
  logic                lsu_hs;
  logic                resp_fire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      starve_cnt_q <= '0;
      wen_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wmask_q      <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      starve_cnt_q <= starve_cnt_d;
      wen_q        <= wen_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wmask_q      <= wmask_d;
    end
  end

  // Arbitration: ready goes only to the winner and only when someone is asking,
  // so both readies sit at 0 while the port is quiet.
  always_comb begin
    idle      = (state_q == IDLE);
    any_valid = ifu_req_valid | lsu_req_valid;
    ifu_wins  = !lsu_req_valid || (ifu_req_valid && (starve_cnt_q == LIMIT));

    ifu_req_ready = rst_n & idle & any_valid & ifu_wins;
    lsu_req_ready = rst_n & idle & !ifu_wins;

    ifu_hs = ifu_req_ready & ifu_req_valid;
    lsu_hs = lsu_req_ready & lsu_req_valid;
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    starve_cnt_d = starve_cnt_q;
    wen_d        = wen_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wmask_d      = wmask_q;

    unique case (state_q)
      IDLE: begin
        if (lsu_hs) begin
          state_d = ISSUE;
          owner_d = 1'b1;
          wen_d   = lsu_wen;
          addr_d  = lsu_addr;
          wdata_d = lsu_wdata;
          wmask_d = lsu_wmask;
          if (ifu_req_valid) begin
            if (starve_cnt_q != LIMIT) starve_cnt_d = starve_cnt_q + 1'b1;
          end else begin
            starve_cnt_d = '0;
          end
        end else if (ifu_hs) begin
          state_d      = ISSUE;
          owner_d      = 1'b0;
          wen_d        = 1'b0;
          addr_d       = ifu_addr;
          wdata_d      = '0;
          wmask_d      = '0;
          starve_cnt_d = '0;
        end
      end
      ISSUE: begin
        // Any response arriving before the request is taken is not ours.
        if (mem_req_ready) state_d = WAIT;
      end
      WAIT: begin
        if (mem_resp_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Response routing is combinational back to whichever side owns the slot.
  always_comb begin
    resp_fire      = rst_n & (state_q == WAIT) & mem_resp_valid;
    ifu_resp_valid = resp_fire & !owner_q;
    lsu_resp_valid = resp_fire & owner_q;
    ifu_rdata      = ifu_resp_valid ? mem_rdata : '0;
    lsu_rdata      = lsu_resp_valid ? mem_rdata : '0;
  end

  always_comb begin
    mem_req_valid = rst_n & (state_q == ISSUE);
    mem_wen       = wen_q;
    mem_addr      = addr_q;
    mem_wdata     = wdata_q;
    mem_wmask     = wmask_q;
    owner         = owner_q;
    busy          = rst_n & (state_q != IDLE);
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: inputs change on the falling edge and
// outputs are checked 1ns later, so the rising edge is where state advances.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        ifu_req_valid, ifu_req_ready;
  logic [31:0] ifu_addr;
  logic        ifu_resp_valid;
  logic [31:0] ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_wen;
  logic [31:0] lsu_addr, lsu_wdata;
  logic [7:0]  lsu_wmask;
  logic        lsu_resp_valid;
  logic [31:0] lsu_rdata;
  logic        mem_req_valid, mem_req_ready, mem_wen;
  logic [31:0] mem_addr, mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_resp_valid;
  logic [31:0] mem_rdata;
  logic        owner, busy;

  int n_tests = 0;
  int n_fail  = 0;

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MASK_W(8), .STARVE_LIMIT(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
    .ifu_addr(ifu_addr), .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
    .lsu_wen(lsu_wen), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_wmask(lsu_wmask), .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
    .owner(owner), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  logic exp_ifu;
  int   exp_cnt;
  logic [31:0] pay;

  initial begin
    rst_n = 1'b0;
    ifu_req_valid = 0; ifu_addr = 0;
    lsu_req_valid = 0; lsu_wen = 0; lsu_addr = 0; lsu_wdata = 0; lsu_wmask = 0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = 0;

    // Reset state
    #3;
    chk1("rst_ifu_ready", ifu_req_ready, 1'b0);
    chk1("rst_lsu_ready", lsu_req_ready, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_mem_req_valid", mem_req_valid, 1'b0);
    chk1("rst_owner", owner, 1'b0);
    chk32("rst_mem_addr", mem_addr, 32'h0);
    settle(); settle();
    rst_n = 1'b1;
    #1;
    chk1("post_rst_ifu_ready", ifu_req_ready, 1'b0);
    chk1("post_rst_lsu_ready", lsu_req_ready, 1'b0);
    chk1("post_rst_busy", busy, 1'b0);

    // Single IFU read
    settle();
    ifu_req_valid = 1; ifu_addr = 32'h8000_0000; mem_req_ready = 1;
    lsu_wen = 1;
    #1;
    chk1("t1_ifu_ready", ifu_req_ready, 1'b1);
    chk1("t1_lsu_ready", lsu_req_ready, 1'b0);
    settle();
    ifu_req_valid = 0; ifu_addr = 32'h0;
    #1;
    chk1("t1_issue_valid", mem_req_valid, 1'b1);
    chk32("t1_issue_addr", mem_addr, 32'h8000_0000);
    chk1("t1_issue_wen", mem_wen, 1'b0);
    chk1("t1_busy", busy, 1'b1);
    chk1("t1_owner", owner, 1'b0);
    chk1("t1_issue_no_resp", ifu_resp_valid, 1'b0);
    settle();
    mem_resp_valid = 1; mem_rdata = 32'h0000_0413;
    #1;
    chk1("t1_ifu_resp", ifu_resp_valid, 1'b1);
    chk32("t1_ifu_rdata", ifu_rdata, 32'h0000_0413);
    chk1("t1_lsu_resp_quiet", lsu_resp_valid, 1'b0);
    chk32("t1_lsu_rdata_zero", lsu_rdata, 32'h0);
    settle();
    mem_resp_valid = 0;
    #1;
    chk1("t1_resp_once", ifu_resp_valid, 1'b0);
    chk32("t1_rdata_zero", ifu_rdata, 32'h0);
    chk1("t1_idle", busy, 1'b0);

    // LSU store
    settle();
    lsu_req_valid = 1; lsu_wen = 1; lsu_addr = 32'h8000_1002;
    lsu_wdata = 32'hBEEF_0000; lsu_wmask = 8'h0C;
    #1;
    chk1("t2_lsu_ready", lsu_req_ready, 1'b1);
    chk1("t2_ifu_ready", ifu_req_ready, 1'b0);
    settle();
    lsu_req_valid = 0; lsu_wen = 0; lsu_addr = 0; lsu_wdata = 0; lsu_wmask = 0;
    #1;
    chk1("t2_issue_valid", mem_req_valid, 1'b1);
    chk1("t2_wen", mem_wen, 1'b1);
    chk32("t2_addr", mem_addr, 32'h8000_1002);
    chk32("t2_wdata", mem_wdata, 32'hBEEF_0000);
    chk32("t2_wmask", {24'd0, mem_wmask}, 32'h0000_000C);
    chk1("t2_owner", owner, 1'b1);
    settle();
    mem_resp_valid = 1; mem_rdata = 32'h1234_5678;
    #1;
    chk1("t2_lsu_resp", lsu_resp_valid, 1'b1);
    chk1("t2_ifu_resp_quiet", ifu_resp_valid, 1'b0);
    settle();
    mem_resp_valid = 0;
    #1;
    chk1("t2_resp_once", lsu_resp_valid, 1'b0);

    // Contention: both requesters held, memory always ready and responding
    settle();
    ifu_req_valid = 1; ifu_addr = 32'h8000_0100;
    lsu_req_valid = 1; lsu_wen = 0; lsu_addr = 32'h8000_2000;
    mem_req_ready = 1; mem_resp_valid = 1;
    exp_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      exp_ifu = (exp_cnt == 4);
      exp_cnt = exp_ifu ? 0 : exp_cnt + 1;
      pay = 32'hA000_0000 + i;
      mem_rdata = pay;
      #1;
      chk1("t3_ifu_ready", ifu_req_ready, exp_ifu);
      chk1("t3_lsu_ready", lsu_req_ready, ~exp_ifu);
      chk1("t3_excl", ifu_req_ready & lsu_req_ready, 1'b0);
      settle();
      #1;
      chk1("t3_issue_owner", owner, ~exp_ifu);
      chk32("t3_issue_addr", mem_addr, exp_ifu ? 32'h8000_0100 : 32'h8000_2000);
      chk1("t3_issue_no_ifu_resp", ifu_resp_valid, 1'b0);
      chk1("t3_issue_no_lsu_resp", lsu_resp_valid, 1'b0);
      chk1("t3_issue_excl", ifu_req_ready | lsu_req_ready, 1'b0);
      settle();
      #1;
      chk1("t3_ifu_resp", ifu_resp_valid, exp_ifu);
      chk1("t3_lsu_resp", lsu_resp_valid, ~exp_ifu);
      chk32("t3_rdata", exp_ifu ? ifu_rdata : lsu_rdata, pay);
      settle();
    end
    ifu_req_valid = 0; lsu_req_valid = 0; mem_resp_valid = 0;
    #1;
    chk1("t3_drain_idle", busy, 1'b0);

    // Backpressure in ISSUE with a spurious response
    settle();
    lsu_req_valid = 1; lsu_wen = 0; lsu_addr = 32'h0000_1234; mem_req_ready = 0;
    #1;
    chk1("t4_lsu_ready", lsu_req_ready, 1'b1);
    settle();
    lsu_req_valid = 0; lsu_addr = 32'hDEAD_DEAD;
    for (int c = 0; c < 5; c++) begin
      mem_resp_valid = (c == 2); mem_rdata = 32'h5555_5555;
      #1;
      chk1("t4_hold_valid", mem_req_valid, 1'b1);
      chk32("t4_hold_addr", mem_addr, 32'h0000_1234);
      chk1("t4_spurious_resp", lsu_resp_valid, 1'b0);
      settle();
    end
    mem_resp_valid = 0; mem_req_ready = 1;
    #1;
    chk1("t4_still_issue", mem_req_valid, 1'b1);
    settle();
    mem_resp_valid = 1; mem_rdata = 32'h0000_CAFE;
    #1;
    chk1("t4_wait_no_req", mem_req_valid, 1'b0);
    chk1("t4_lsu_resp", lsu_resp_valid, 1'b1);
    chk32("t4_lsu_rdata", lsu_rdata, 32'h0000_CAFE);
    settle();
    mem_resp_valid = 0;
    #1;
    chk1("t4_idle", busy, 1'b0);
    chk32("t4_rdata_zero", lsu_rdata, 32'h0);

    // Reset while WAITing for a response
    settle();
    ifu_req_valid = 1; ifu_addr = 32'h8000_0004;
    settle();
    ifu_req_valid = 0;
    settle();
    #1;
    chk1("t5_in_wait", busy, 1'b1);
    #1;
    rst_n = 0; mem_resp_valid = 1; mem_rdata = 32'hFFFF_FFFF; ifu_req_valid = 1;
    #1;
    chk1("t5_rst_busy", busy, 1'b0);
    chk1("t5_rst_ifu_resp", ifu_resp_valid, 1'b0);
    chk32("t5_rst_ifu_rdata", ifu_rdata, 32'h0);
    chk1("t5_rst_ifu_ready", ifu_req_ready, 1'b0);
    chk1("t5_rst_mem_req", mem_req_valid, 1'b0);
    chk32("t5_rst_mem_addr", mem_addr, 32'h0);
    chk1("t5_rst_owner", owner, 1'b0);
    settle();
    ifu_req_valid = 0; mem_resp_valid = 0;
    settle();
    rst_n = 1;
    #1;
    chk1("t5_post_busy", busy, 1'b0);
    settle();
    ifu_req_valid = 1; ifu_addr = 32'h8000_0008;
    #1;
    chk1("t5_new_ready", ifu_req_ready, 1'b1);
    settle();
    ifu_req_valid = 0;
    #1;
    chk32("t5_new_addr", mem_addr, 32'h8000_0008);
    settle();
    mem_resp_valid = 1; mem_rdata = 32'h0010_0073;
    #1;
    chk1("t5_new_resp", ifu_resp_valid, 1'b1);
    chk32("t5_new_rdata", ifu_rdata, 32'h0010_0073);
    settle();
    mem_resp_valid = 0;
    #1;
    chk1("t5_done", busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the end of the directed sequence");
    $fatal(1, "timeout");
  end

endmodule
